// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write path: requester indices
// and default address/data widths.
package regfile_pkg;

  // Requester indices into the req/gnt vectors.
  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  // Default geometry of the register file and its write port.
  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 4;
  localparam int DEF_DW   = 16;

endpackage : regfile_pkg

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the write requesters and the register-file write arbiter.
//
// Handshake: req[i] is a level request carrying req_addr/req_data slice i.
// The arbiter answers with gnt[i], a one-cycle pulse registered on the edge
// after selection, together with wr_addr/wr_data.
// A requester that keeps req[i] high after its pulse is treated as a brand-new
// request. It is not eligible in the cycle its own gnt[i] is high.
// While stall is high no selection is made and requests simply wait.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
);

  logic                 stall;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [7:0]           wr_count;

  // Requester side: drives requests, observes grants and the write port.
  modport master (
    output stall, req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data, wr_count
  );

  // Arbiter side.
  modport slave (
    input  stall, req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data, wr_count
  );

endinterface : regfile_write_arbiter_if

// File: rtl/rr_pick.sv
// Combinational round-robin search: scans the request vector upward from
// i_start with wrap-around and returns the first set bit as a one-hot winner.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_onehot,
  output logic          o_valid
);

  // One bit wider than an index so start+offset cannot overflow before wrap.
  logic [IW:0] w_idx;

  // Walk the N positions starting at i_start and keep only the first hit.
  always_comb begin
    o_onehot = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, i_start} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(N)) begin
        w_idx = w_idx - (IW+1)'(N);
      end
      if (!o_valid && i_req[w_idx[IW-1:0]]) begin
        o_onehot[w_idx[IW-1:0]] = 1'b1;
        o_valid                 = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that funnels several register-file write requesters
// onto a single registered write port. Writes to register 0 are granted
// (the requester sees its pulse) but never reach the register file.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] r_gnt;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic [7:0]      r_wr_count;
  logic [IW-1:0]   r_last;

  logic [NREQ-1:0] w_elig;
  logic [IW-1:0]   w_start;
  logic [NREQ-1:0] w_pick_oh;
  logic            w_pick_vld;
  logic [IW-1:0]   w_pick_idx;
  logic [AW-1:0]   w_pick_addr;
  logic [DW-1:0]   w_pick_data;
  logic            w_grant;
  logic            w_wr_en_next;

  // A requester currently holding its grant pulse sits out this round.
  assign w_elig  = bus.req & ~r_gnt;
  assign w_start = (r_last == IW'(NREQ-1)) ? '0 : r_last + 1'b1;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req    (w_elig),
    .i_start  (w_start),
    .o_onehot (w_pick_oh),
    .o_valid  (w_pick_vld)
  );

  // Decode the one-hot winner into an index and route its address/data.
  always_comb begin
    w_pick_idx  = '0;
    w_pick_addr = '0;
    w_pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_oh[i]) begin
        w_pick_idx  = IW'(i);
        w_pick_addr = bus.req_addr[i*AW +: AW];
        w_pick_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign w_grant      = w_pick_vld & ~bus.stall;
  // Register 0 is hard-wired: its writes are acknowledged but dropped here.
  assign w_wr_en_next = w_grant & (w_pick_addr != '0);

  // Register the grant, the write port and the rotating priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_count <= '0;
      r_last     <= IW'(NREQ-1);
    end else begin
      r_gnt      <= w_grant ? w_pick_oh : '0;
      r_wr_en    <= w_wr_en_next;
      r_wr_count <= r_wr_count + 8'(w_wr_en_next);
      if (w_grant) begin
        r_wr_addr <= w_pick_addr;
        r_wr_data <= w_pick_data;
        r_last    <= w_pick_idx;
      end
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wr_count = r_wr_count;

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a vector table for the
// single-cycle behaviour plus hand-written multi-cycle sequences.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic mon_en;

  regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall;
    logic [2:0]  req;
    logic [3:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic [2:0]  e_gnt;
    logic        e_en;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic [7:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  logic [2:0] exp_q [$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic [2:0] rq,
                       input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    bus.stall    = st;
    bus.req      = rq;
    bus.req_addr = {a2, a1, a0};
    bus.req_data = {d2, d1, d0};
  endtask

  // Advance one edge and settle before outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] g, input logic en,
                           input logic [3:0] ad, input logic [15:0] dt, input logic [7:0] c);
    check({tag, ".gnt"},      32'(bus.gnt),      32'(g));
    check({tag, ".wr_en"},    32'(bus.wr_en),    32'(en));
    check({tag, ".wr_addr"},  32'(bus.wr_addr),  32'(ad));
    check({tag, ".wr_data"},  32'(bus.wr_data),  32'(dt));
    check({tag, ".wr_count"}, 32'(bus.wr_count), 32'(c));
  endtask

  // ---------------- one-hot monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ($countones(bus.gnt) > 1) begin
        n_fail++;
        $display("FAIL onehot: gnt=%b has more than one bit set at %0t", bus.gnt, $time);
      end
    end
  end

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int g_cnt [3];
    logic [2:0] e;

    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;

    //                stall req     a0    a1    a2    d0        d1        d2        gnt     en    addr  data      cnt
    vecs[0]  = '{1'b0, 3'b001, 4'd3, 4'd0, 4'd0, 16'h1234, 16'h0000, 16'h0000, 3'b001, 1'b1, 4'd3, 16'h1234, 8'd1};
    vecs[1]  = '{1'b0, 3'b000, 4'd3, 4'd0, 4'd0, 16'h1234, 16'h0000, 16'h0000, 3'b000, 1'b0, 4'd3, 16'h1234, 8'd1};
    vecs[2]  = '{1'b0, 3'b010, 4'd0, 4'd0, 4'd0, 16'h0000, 16'hFFFF, 16'h0000, 3'b010, 1'b0, 4'd0, 16'hFFFF, 8'd1};
    vecs[3]  = '{1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'hFFFF, 16'h0000, 3'b000, 1'b0, 4'd0, 16'hFFFF, 8'd1};
    vecs[4]  = '{1'b0, 3'b110, 4'd0, 4'd5, 4'd7, 16'h0000, 16'h1111, 16'h2222, 3'b100, 1'b1, 4'd7, 16'h2222, 8'd2};
    vecs[5]  = '{1'b0, 3'b110, 4'd0, 4'd5, 4'd7, 16'h0000, 16'h1111, 16'h2222, 3'b010, 1'b1, 4'd5, 16'h1111, 8'd3};
    vecs[6]  = '{1'b0, 3'b110, 4'd0, 4'd5, 4'd7, 16'h0000, 16'h1111, 16'h2222, 3'b100, 1'b1, 4'd7, 16'h2222, 8'd4};
    vecs[7]  = '{1'b0, 3'b011, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b001, 1'b1, 4'd9, 16'hAAAA, 8'd5};
    vecs[8]  = '{1'b0, 3'b011, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b010, 1'b1, 4'd5, 16'h1111, 8'd6};
    vecs[9]  = '{1'b0, 3'b000, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b000, 1'b0, 4'd5, 16'h1111, 8'd6};
    vecs[10] = '{1'b0, 3'b101, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b100, 1'b1, 4'd7, 16'h2222, 8'd7};
    vecs[11] = '{1'b0, 3'b000, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b000, 1'b0, 4'd7, 16'h2222, 8'd7};
    vecs[12] = '{1'b1, 3'b100, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b000, 1'b0, 4'd7, 16'h2222, 8'd7};
    vecs[13] = '{1'b1, 3'b100, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b000, 1'b0, 4'd7, 16'h2222, 8'd7};
    vecs[14] = '{1'b1, 3'b100, 4'd9, 4'd5, 4'd7, 16'hAAAA, 16'h1111, 16'h2222, 3'b000, 1'b0, 4'd7, 16'h2222, 8'd7};
    vecs[15] = '{1'b0, 3'b100, 4'd9, 4'd5, 4'd4, 16'hAAAA, 16'h1111, 16'h4444, 3'b100, 1'b1, 4'd4, 16'h4444, 8'd8};
    vecs[16] = '{1'b1, 3'b011, 4'd9, 4'd5, 4'd4, 16'hAAAA, 16'h1111, 16'h4444, 3'b000, 1'b0, 4'd4, 16'h4444, 8'd8};
    vecs[17] = '{1'b0, 3'b011, 4'd9, 4'd5, 4'd4, 16'hAAAA, 16'h1111, 16'h4444, 3'b001, 1'b1, 4'd9, 16'hAAAA, 8'd9};
    vecs[18] = '{1'b0, 3'b000, 4'd9, 4'd5, 4'd4, 16'hAAAA, 16'h1111, 16'h4444, 3'b000, 1'b0, 4'd9, 16'hAAAA, 8'd9};

    // Reset while requesters 0 and 1 are asking: nothing may come out.
    reset = 1'b1;
    drive(1'b0, 3'b011, 4'd6, 4'd8, 4'd0, 16'h0600, 16'h0800, 16'h0000);
    tick();
    mon_en = 1'b1;
    check_all("rst", 3'b000, 1'b0, 4'd0, 16'h0000, 8'd0);

    // Release: requester 0 has first priority.
    reset = 1'b0;
    tick();
    check_all("rst_rel", 3'b001, 1'b1, 4'd6, 16'h0600, 8'd1);

    // Reset again with requester 1 about to win: that grant is dropped.
    reset = 1'b1;
    tick();
    check_all("rst_drop", 3'b000, 1'b0, 4'd0, 16'h0000, 8'd0);
    reset = 1'b0;
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    check_all("idle", 3'b000, 1'b0, 4'd0, 16'h0000, 8'd0);

    // Table-driven single-cycle behaviour.
    for (int v = 0; v < NVEC; v++) begin
      drive(vecs[v].stall, vecs[v].req, vecs[v].a0, vecs[v].a1, vecs[v].a2,
            vecs[v].d0, vecs[v].d1, vecs[v].d2);
      tick();
      check_all($sformatf("vec%0d", v), vecs[v].e_gnt, vecs[v].e_en,
                vecs[v].e_addr, vecs[v].e_data, vecs[v].e_cnt);
    end

    // All three requesting continuously from reset: strict rotation.
    reset = 1'b1;
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    reset = 1'b0;
    drive(1'b0, 3'b111, 4'd1, 4'd2, 4'd3, 16'h0010, 16'h0020, 16'h0030);
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int j = 0; j < 3; j++) g_cnt[j] = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("rr%0d.gnt", c), 32'(bus.gnt), 32'(e));
      for (int j = 0; j < 3; j++) begin
        if (bus.gnt[j]) g_cnt[j]++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rr_fair%0d", j), 32'(g_cnt[j]), 32'd2);
    end
    check("rr.wr_count", 32'(bus.wr_count), 32'd6);
    check("rr.wr_addr", 32'(bus.wr_addr), 32'd3);

    // Write-counter wrap: 257 single grants from a fresh reset.
    reset = 1'b1;
    drive(1'b0, 3'b000, 4'd1, 4'd0, 4'd0, 16'h0001, 16'h0000, 16'h0000);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      drive(1'b0, 3'b001, 4'd1, 4'd0, 4'd0, 16'(i), 16'h0000, 16'h0000);
      tick();
      if (i >= 255) begin
        check($sformatf("wrap%0d.wr_count", i), 32'(bus.wr_count), 32'(i % 256));
        check($sformatf("wrap%0d.wr_en", i), 32'(bus.wr_en), 32'd1);
      end
      drive(1'b0, 3'b000, 4'd1, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
      tick();
    end
    check("wrap.idle_gnt", 32'(bus.gnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_write_arbiter
